// File: rtl/prg_injector.sv
// PRG file injector: strips the two-byte load-address header, writes the payload into
// PET RAM, then patches the BASIC end-of-program pointers with the end address.
module prg_injector #(
    parameter logic [7:0]  PRG_INDEX = 8'h41,
    parameter logic [15:0] PTR_BASE  = 16'h007C,
    parameter int          NPTR      = 3,
    parameter logic [15:0] RAM_LIMIT = 16'h3FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [13:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int KW = $clog2(2 * NPTR + 1);
    localparam logic [KW-1:0] PATCH_END = KW'(2 * NPTR);

    typedef enum logic [2:0] {IDLE, HDR, DATA, PATCH, ABORT} state_t;

    state_t        state, state_next;
    logic          dl_prev;
    logic [15:0]   load_addr;
    logic [15:0]   end_addr;
    logic          data_seen;
    logic [KW-1:0] patch_k;

    logic          is_prg, dl_rise, dl_fall, accepted;
    logic [15:0]   target, target_inc;
    logic [13:0]   patch_addr;

    assign is_prg     = (ioctl_index == PRG_INDEX);
    assign dl_rise    = ioctl_download & ~dl_prev & is_prg;
    assign dl_fall    = ~ioctl_download & dl_prev;
    assign accepted   = ioctl_wr & ioctl_download & is_prg;
    assign target     = load_addr + ioctl_addr[15:0] - 16'd2;
    assign target_inc = target + 16'd1;
    assign patch_addr = PTR_BASE[13:0] + 14'(patch_k);
    assign busy       = (state != IDLE);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets its default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (dl_rise) state_next = HDR;
            HDR: begin
                if (dl_fall)                                 state_next = IDLE;
                else if (accepted && ioctl_addr == 25'd1)    state_next = DATA;
            end
            DATA:  if (dl_fall) state_next = data_seen ? PATCH : IDLE;
            PATCH: begin
                if (dl_rise)                             state_next = ABORT;
                else if (err || patch_k == PATCH_END)    state_next = IDLE;
            end
            ABORT: state_next = HDR;
            default: state_next = IDLE;
        endcase
    end

    // Held high across reset so a download already in flight is not mistaken for a new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dl_prev <= 1'b1;
        else       dl_prev <= ioctl_download;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_we    <= 1'b0;
            dma_addr  <= '0;
            dma_din   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_addr <= '0;
            end_addr  <= '0;
            data_seen <= 1'b0;
            patch_k   <= '0;
        end else begin
            dma_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (dl_rise) begin
                        err       <= 1'b0;
                        load_addr <= '0;
                        data_seen <= 1'b0;
                    end
                end
                HDR: begin
                    if (dl_fall) begin
                        err <= 1'b1;
                    end else if (accepted) begin
                        if (ioctl_addr == 25'd0) load_addr[7:0]  <= ioctl_dout;
                        if (ioctl_addr == 25'd1) load_addr[15:8] <= ioctl_dout;
                    end
                end
                DATA: begin
                    if (dl_fall) begin
                        if (!data_seen) err <= 1'b1;
                        patch_k <= '0;
                    end else if (accepted) begin
                        data_seen <= 1'b1;
                        end_addr  <= target_inc;
                        if (target > RAM_LIMIT) begin
                            err <= 1'b1;
                        end else begin
                            dma_we   <= 1'b1;
                            dma_addr <= target[13:0];
                            dma_din  <= ioctl_dout;
                        end
                    end
                end
                PATCH: begin
                    if (!dl_rise) begin
                        if (err || patch_k == PATCH_END) begin
                            done <= 1'b1;
                        end else begin
                            dma_we   <= 1'b1;
                            dma_addr <= patch_addr;
                            dma_din  <= patch_k[0] ? end_addr[15:8] : end_addr[7:0];
                            patch_k  <= patch_k + 1'b1;
                        end
                    end
                end
                ABORT: begin
                    err       <= 1'b1;
                    load_addr <= '0;
                    data_seen <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prg_injector.sv
// Directed and randomized PRG downloads checked against a byte-list reference model
// that derives the expected RAM writes, error flag and done pulse from the file contents.
module tb_prg_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [13:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        busy;
    logic        done;
    logic        err;

    prg_injector dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  stim[$];
    logic [21:0] obs_q[$];
    logic [21:0] exp_q[$];
    int          done_cnt;
    bit          busy_seen;
    bit          exp_err;
    int          exp_done;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (dma_we) obs_q.push_back({dma_addr, dma_din});
        if (done)   done_cnt++;
        if (busy)   busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: PRG file -> list of RAM writes, error flag, done pulse count.
    task automatic build_model(input logic [7:0] idx, input bit err_in);
        logic [15:0] load, t, end_a;
        exp_q.delete();
        exp_err  = err_in;
        exp_done = 0;
        end_a    = 16'h0000;
        if (idx != 8'h41) return;
        exp_err = err_in;
        if (stim.size() < 3) begin
            exp_err = 1'b1;
            return;
        end
        load = {stim[1], stim[0]};
        for (int i = 2; i < stim.size(); i++) begin
            t = load + 16'(i - 2);
            if (t > 16'h3FFF) exp_err = 1'b1;
            else              exp_q.push_back({t[13:0], stim[i]});
            end_a = t + 16'd1;
        end
        if (!exp_err)
            for (int k = 0; k < 6; k++)
                exp_q.push_back({14'(16'h007C + k), (k % 2 == 1) ? end_a[15:8] : end_a[7:0]});
        exp_done = 1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        cyc(1);
    endtask

    task automatic send_bytes(input int max_gap);
        for (int i = 0; i < stim.size(); i++) begin
            cyc($urandom_range(0, max_gap));
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = stim[i];
            cyc(1);
            ioctl_wr   = 1'b0;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, "_done"}, done_cnt, exp_done);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic run(input string tag, input logic [7:0] idx, input int max_gap, input bit err_in);
        obs_q.delete();
        done_cnt  = 0;
        busy_seen = 1'b0;
        start_dl(idx);
        send_bytes(max_gap);
        ioctl_download = 1'b0;
        cyc(25);
        build_model(idx, err_in);
        compare(tag);
    endtask

    task automatic wait_write(input logic [13:0] addr, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dma_we && dma_addr == addr) found = 1'b1;
        end
    endtask

    initial begin
        bit          found;
        logic [15:0] load;
        int          len;

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        #1;
        check("rst_we",   dma_we,   1'b0);
        check("rst_done", done,     1'b0);
        check("rst_busy", busy,     1'b0);
        check("rst_err",  err,      1'b0);
        check("rst_addr", dma_addr, 14'h0);
        check("rst_din",  dma_din,  8'h0);
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // Basic three-byte program.
        stim = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
        run("basic", 8'h41, 0, 1'b0);
        check("basic_first", obs_q.size() > 0 ? obs_q[0] : 22'h0, {14'h0401, 8'hAA});

        // Load at RAM top: only 3FFF is writable.
        stim = '{8'hFF, 8'h3F, 8'h11, 8'h22, 8'h33};
        run("limit", 8'h41, 1, 1'b0);

        // One header byte only.
        stim = '{8'h05};
        run("short", 8'h41, 0, 1'b0);

        // Foreign download index is ignored entirely; err keeps its previous value.
        stim = '{8'h00, 8'h10, 8'h01, 8'h02};
        run("foreign", 8'h01, 0, err);
        check("foreign_busy", busy_seen, 1'b0);

        // 256 back-to-back data bytes at 0x0401.
        stim = '{8'h01, 8'h04};
        for (int i = 0; i < 256; i++) stim.push_back(8'($urandom));
        run("burst", 8'h41, 0, 1'b0);

        // Randomized downloads, including loads near the RAM limit and 16-bit wrap.
        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 2))
                0:       load = 16'($urandom_range(0, 16'h3F00));
                1:       load = 16'h3FF0 + 16'($urandom_range(0, 15));
                default: load = 16'hFFF0 + 16'($urandom_range(0, 15));
            endcase
            len = $urandom_range(1, 24);
            stim = '{load[7:0], load[15:8]};
            for (int i = 2; i < len; i++) stim.push_back(8'($urandom));
            while (stim.size() > len) void'(stim.pop_back());
            run($sformatf("rnd%0d", r), 8'h41, 2, 1'b0);
        end

        // Reset asserted during the second pointer write.
        stim = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
        start_dl(8'h41);
        send_bytes(0);
        ioctl_download = 1'b0;
        wait_write(14'h007D, found);
        check("rst_mid_found", found, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_we",   dma_we,   1'b0);
        check("rst_mid_done", done,     1'b0);
        check("rst_mid_busy", busy,     1'b0);
        check("rst_mid_err",  err,      1'b0);
        check("rst_mid_addr", dma_addr, 14'h0);
        check("rst_mid_din",  dma_din,  8'h0);
        cyc(2);
        reset = 1'b0;
        obs_q.delete();
        cyc(10);
        check("rst_mid_quiet", obs_q.size(), 0);
        run("after_rst", 8'h41, 0, 1'b0);

        // New download arriving mid-patch aborts the patch and leaves err set.
        stim = '{8'h00, 8'h10, 8'h01, 8'h02, 8'h03};
        start_dl(8'h41);
        send_bytes(0);
        ioctl_download = 1'b0;
        wait_write(14'h007C, found);
        check("abort_found", found, 1'b1);
        cyc(1);
        ioctl_download = 1'b1;
        cyc(3);
        check("abort_err",  err,  1'b1);
        check("abort_busy", busy, 1'b1);
        obs_q.delete();
        done_cnt = 0;
        stim = '{8'h00, 8'h20, 8'h55, 8'h66};
        send_bytes(1);
        ioctl_download = 1'b0;
        cyc(25);
        build_model(8'h41, 1'b1);
        compare("abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prg_injector.md
PRG_INJECTOR -- requirements
Module: prg_injector

Interface
REQ-001 Parameter PRG_INDEX, default 8'h41, ioctl_index value that selects a PRG download.
REQ-002 Parameter PTR_BASE, default 16'h007C, address of the first BASIC end-of-program pointer (low byte first).
REQ-003 Parameter NPTR, default 3, number of consecutive 16-bit pointers patched with the end address.
REQ-004 Parameter RAM_LIMIT, default 16'h3FFF, highest writable PET RAM address.
REQ-005 clk  in  1  system clock; every port is sampled on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ioctl_download  in  1  download in progress.
REQ-008 ioctl_index  in  8  download type selector.
REQ-009 ioctl_wr  in  1  one-cycle byte strobe.
REQ-010 ioctl_addr  in  25  file byte offset.
REQ-011 ioctl_dout  in  8  file byte.
REQ-012 dma_addr  out  14  PET RAM write address.
REQ-013 dma_din  out  8  PET RAM write data.
REQ-014 dma_we  out  1  one-cycle RAM write strobe.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse when pointer patching completes.
REQ-017 err  out  1  sticky error flag; cleared when the next PRG download starts.

Function
REQ-018 The FSM states SHALL be IDLE, HDR, DATA, PATCH, and ABORT.
REQ-019 A byte is "accepted" when ioctl_wr=1, ioctl_download=1, and ioctl_index=PRG_INDEX.
REQ-020 IDLE->HDR SHALL occur on a rising edge of ioctl_download with ioctl_index=PRG_INDEX, and SHALL clear err, load_addr, and byte_cnt.
REQ-021 In HDR, an accepted byte at offset 0 SHALL load load_addr[7:0]; offset 1 SHALL load load_addr[15:8] and move the FSM to DATA.
REQ-022 HDR bytes SHALL NOT generate dma_we.
REQ-023 In DATA, each accepted byte SHALL produce dma_we=1 exactly one cycle later.
REQ-024 That write SHALL use dma_addr=(load_addr+ioctl_addr-2)[13:0] and dma_din=ioctl_dout, both registered with the strobe.
REQ-025 Accepted bytes on back-to-back cycles SHALL each produce their own pulse, with no loss and no backpressure.
REQ-026 The 16-bit target address SHALL be computed modulo 2^16.
REQ-027 A target address > RAM_LIMIT SHALL suppress dma_we for that byte and set err.
REQ-028 end_addr SHALL track (target address of the last accepted DATA byte)+1, modulo 2^16.
REQ-029 ioctl_download falling in DATA with at least one data byte accepted SHALL move the FSM to PATCH.
REQ-030 ioctl_download falling in HDR, or in DATA with zero data bytes, SHALL set err and return to IDLE without patching.
REQ-031 PATCH SHALL issue 2*NPTR writes on consecutive cycles.
REQ-032 PATCH write k (k=0..2*NPTR-1) SHALL use address PTR_BASE+k, with data end_addr[7:0] for even k and end_addr[15:8] for odd k.
REQ-033 After the last PATCH write, done SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-034 PATCH SHALL be skipped (FSM goes to IDLE, done still pulses) if err is set.
REQ-035 A new PRG download rising edge during PATCH SHALL move the FSM to ABORT.
REQ-036 ABORT SHALL end the patch sequence, set err, and enter HDR on the next cycle.
REQ-037 The pending DATA write pipeline SHALL drain, so a byte accepted in the cycle ioctl_download falls is still written before PATCH begins.
REQ-038 Downloads with a different ioctl_index SHALL be ignored in every state.
REQ-039 Downloads with a different ioctl_index SHALL never assert dma_we.
REQ-040 At most one dma_we SHALL be asserted per cycle.

Reset
REQ-041 While reset=1, and asynchronously on its assertion, the FSM SHALL enter IDLE.
REQ-042 While reset=1, dma_we, done, busy, and err SHALL be 0.
REQ-043 While reset=1, dma_addr, dma_din, load_addr, and end_addr SHALL be 0.
REQ-044 Reset asserted mid-DATA or mid-PATCH SHALL drop any pending write.
REQ-045 After reset releases, no write SHALL occur until a new PRG download starts.

Verification
REQ-046 PRG bytes 01 04 AA BB CC -> writes 0401=AA, 0402=BB, 0403=CC; then 007C..0081 = 04,04,04,04,04,04; then done pulses once.
REQ-047 Header FF 3F plus 3 data bytes -> only 3FFF is written; err=1; no PATCH writes; done pulses.
REQ-048 Download of 1 byte only -> err=1, zero dma_we pulses, done never pulses.
REQ-049 ioctl_index=01 download -> zero dma_we, busy stays 0.
REQ-050 Consecutive-cycle ioctl_wr across 256 data bytes at load 0x0401 -> 256 strobes with addresses 0401..0500 in order.
REQ-051 Reset asserted during the 2nd PATCH write -> outputs are 0 immediately; a subsequent clean download behaves per REQ-046.
